ex_muldiv_iter: RTL and testbench

Iterative multiply/divide unit for the EX stage, implementing the eight RV32M operations selected by funct3. It accepts one operation through a start/done handshake and computes one bit per cycle. While busy it holds `stall_o` high so hazard detection freezes PC, IF/ID and ID/EX. The result and destination register tag are returned for insertion into EX/MEM. Width is parametrised so the same unit serves narrower test cores.

---
 rtl/ex_muldiv_iter_pkg.sv | 22 ++
 rtl/ex_muldiv_iter_if.sv | 26 ++
 rtl/ex_muldiv_iter.sv | 133 +++++++++++++
 tb/tb_ex_muldiv_iter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_iter_pkg.sv
// Shared CPU definitions used by the iterative multiply/divide unit:
// RV32M funct3 encodings and the MULDIV sequencer state type.
package cpu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP,
        ST_DONE
    } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_iter_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
interface ex_muldiv_iter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             start_i;
    logic             flush_i;
    logic [2:0]       funct3_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [TAG_W-1:0] rd_i;
    logic             stall_o;
    logic             done_o;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] rd_o;

    modport master (
        output start_i, flush_i, funct3_i, rs1_i, rs2_i, rd_i,
        input  stall_o, done_o, result_o, rd_o
    );

    modport slave (
        input  start_i, flush_i, funct3_i, rs1_i, rs2_i, rd_i,
        output stall_o, done_o, result_o, rd_o
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative RV32M multiply/divide: one bit per cycle on unsigned magnitudes,
// sign fix-up afterwards; MUL and DIV share one 2*XLEN accumulator.
module ex_muldiv_iter
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ex_muldiv_iter_if.slave   bus
);

    localparam int unsigned     CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e      r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_result;
    logic [2:0]         r_op;
    logic               r_neg_q, r_neg_r;
    logic [TAG_W-1:0]   r_rd, r_rd_o;

    logic               w_accept, w_sgn1, w_sgn2, w_neg1, w_neg2;
    logic               w_div0, w_ovf, w_special;
    logic [XLEN-1:0]    w_mag1, w_mag2, w_special_res;
    logic [XLEN:0]      w_mul_sum, w_div_trial;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_quo, w_rem, w_fix;

    always_comb begin
        w_accept = bus.start_i & ~bus.flush_i;
        w_sgn1   = (bus.funct3_i == F3_MULH) | (bus.funct3_i == F3_MULHSU) |
                   (bus.funct3_i == F3_DIV)  | (bus.funct3_i == F3_REM);
        w_sgn2   = (bus.funct3_i == F3_MULH) | (bus.funct3_i == F3_DIV) |
                   (bus.funct3_i == F3_REM);
        w_neg1   = w_sgn1 & bus.rs1_i[XLEN-1];
        w_neg2   = w_sgn2 & bus.rs2_i[XLEN-1];
        w_mag1   = w_neg1 ? -bus.rs1_i : bus.rs1_i;
        w_mag2   = w_neg2 ? -bus.rs2_i : bus.rs2_i;
        // Only signed DIV/REM (funct3[0]=0) can overflow.
        w_div0   = (bus.rs2_i == '0);
        w_ovf    = ~bus.funct3_i[0] & (bus.rs1_i == MOST_NEG) & (bus.rs2_i == '1);
        w_special = bus.funct3_i[2] & (w_div0 | w_ovf);
        if (w_div0) w_special_res = bus.funct3_i[1] ? bus.rs1_i : '1;
        else        w_special_res = bus.funct3_i[1] ? '0 : bus.rs1_i;
    end

    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
        w_prod      = r_neg_q ? -r_acc : r_acc;
        w_quo       = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem       = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        if (!r_op[2]) w_fix = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        else          w_fix = r_op[1] ? w_rem : w_quo;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:
                if (w_accept)
                    w_state_nxt = w_special ? ST_DONE : (bus.funct3_i[2] ? ST_DIV : ST_MUL);
            ST_MUL, ST_DIV:
                if (bus.flush_i)              w_state_nxt = ST_IDLE;
                else if (r_cnt == CNT_LAST)   w_state_nxt = ST_FIXUP;
            ST_FIXUP: w_state_nxt = bus.flush_i ? ST_IDLE : ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rd     <= '0;
            r_result <= '0;
            r_rd_o   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_cnt   <= '0;
                    r_op    <= bus.funct3_i;
                    r_rd    <= bus.rd_i;
                    r_neg_q <= w_neg1 ^ w_neg2;
                    r_neg_r <= w_neg1;
                    r_acc   <= {{XLEN{1'b0}}, w_mag1};
                    r_b     <= w_mag2;
                    if (w_special) begin
                        r_result <= w_special_res;
                        r_rd_o   <= bus.rd_i;
                    end
                end
                ST_MUL: if (!bus.flush_i) begin
                    r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                end
                // Restoring step: keep the shifted remainder when the trial borrows.
                ST_DIV: if (!bus.flush_i) begin
                    r_acc <= w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                               : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                end
                ST_FIXUP: if (!bus.flush_i) begin
                    r_result <= w_fix;
                    r_rd_o   <= r_rd;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall_o  = ((r_state == ST_IDLE) && w_accept) || (r_state == ST_MUL) ||
                          (r_state == ST_DIV) || (r_state == ST_FIXUP);
    assign bus.done_o   = (r_state == ST_DONE);
    assign bus.result_o = r_result;
    assign bus.rd_o     = r_rd_o;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Bench for ex_muldiv_iter: 32-bit and 8-bit instances checked every cycle
// against an arithmetic reference model plus directed literal results.
module tb_ex_muldiv_iter;
    import cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    int unsigned cyc   = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    ex_muldiv_iter_if #(.XLEN(32), .TAG_W(5)) if32 ();
    ex_muldiv_iter_if #(.XLEN(8),  .TAG_W(3)) if8 ();

    ex_muldiv_iter #(.XLEN(32), .TAG_W(5)) dut32 (.clk_i(clk_i), .rst_i(rst_i), .bus(if32));
    ex_muldiv_iter #(.XLEN(8),  .TAG_W(3)) dut8  (.clk_i(clk_i), .rst_i(rst_i), .bus(if8));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] b, input int unsigned w);
        logic [63:0]         m;
        logic signed [127:0] sa, sb, ua, ub, p;
        logic [127:0]        q;
        m  = (64'd1 << w) - 64'd1;
        ua = {64'd0, a & m};
        ub = {64'd0, b & m};
        sa = ua;
        sb = ub;
        if (a[w-1]) sa = ua - (128'd1 << w);
        if (b[w-1]) sb = ub - (128'd1 << w);
        p = '0;
        case (f3)
            F3_MUL:    p = ua * ub;
            F3_MULH:   p = (sa * sb) >>> w;
            F3_MULHSU: p = (sa * ub) >>> w;
            F3_MULHU:  p = (ua * ub) >> w;
            F3_DIV:
                if (ub == 0) p = {64'd0, m};
                else if (ua == (128'd1 << (w - 1)) && ub == {64'd0, m}) p = ua;
                else p = sa / sb;
            F3_DIVU:   p = (ub == 0) ? {64'd0, m} : ua / ub;
            F3_REM:
                if (ub == 0) p = ua;
                else if (ua == (128'd1 << (w - 1)) && ub == {64'd0, m}) p = '0;
                else p = sa % sb;
            default:   p = (ub == 0) ? ua : ua % ub;
        endcase
        q = p;
        return q[63:0] & m;
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [63:0] a,
                                      input logic [63:0] b, input int unsigned w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return f3[2] && (((b & m) == 0) ||
               (!f3[0] && (a & m) == (64'd1 << (w - 1)) && (b & m) == m));
    endfunction

    // Reference model state, one slot per instance (0: XLEN=32, 1: XLEN=8).
    int unsigned W[2] = '{32, 8};
    bit          m_busy[2];
    int unsigned m_done_cyc[2];
    logic [63:0] m_res[2], m_last_res[2];
    logic [7:0]  m_rd[2], m_last_rd[2];

    task automatic model_step(input int u, input logic st, input logic fl, input logic [2:0] f3,
                              input logic [63:0] a, input logic [63:0] b, input logic [7:0] rd,
                              input logic stall, input logic done,
                              input logic [63:0] res, input logic [7:0] rdo);
        logic exp_done, exp_stall;
        exp_done  = 1'b0;
        exp_stall = st & ~fl;
        if (!rst_i) begin
            m_busy[u] = 1'b0;
            m_last_res[u] = '0;
            m_last_rd[u] = '0;
        end else if (!m_busy[u]) begin
            if (st && !fl) begin
                m_busy[u]     = 1'b1;
                m_res[u]      = ref_op(f3, a, b, W[u]);
                m_rd[u]       = rd;
                m_done_cyc[u] = cyc + 1 + (is_special(f3, a, b, W[u]) ? 0 : W[u] + 1);
            end
        end else if (cyc == m_done_cyc[u]) begin
            exp_done      = 1'b1;
            exp_stall     = 1'b0;
            m_busy[u]     = 1'b0;
            m_last_res[u] = m_res[u];
            m_last_rd[u]  = m_rd[u];
        end else begin
            exp_stall = 1'b1;
            if (fl) m_busy[u] = 1'b0;
        end
        chk($sformatf("u%0d_done", u),   {63'd0, done},  {63'd0, exp_done});
        chk($sformatf("u%0d_stall", u),  {63'd0, stall}, {63'd0, exp_stall});
        chk($sformatf("u%0d_result", u), res, m_last_res[u]);
        chk($sformatf("u%0d_rd", u),     {56'd0, rdo}, {56'd0, m_last_rd[u]});
    endtask

    always @(negedge clk_i) begin
        model_step(0, if32.start_i, if32.flush_i, if32.funct3_i, 64'(if32.rs1_i), 64'(if32.rs2_i),
                   8'(if32.rd_i), if32.stall_o, if32.done_o, 64'(if32.result_o), 8'(if32.rd_o));
        model_step(1, if8.start_i, if8.flush_i, if8.funct3_i, 64'(if8.rs1_i), 64'(if8.rs2_i),
                   8'(if8.rd_i), if8.stall_o, if8.done_o, 64'(if8.result_o), 8'(if8.rd_o));
    end

    task automatic set_in(input int u, input logic st, input logic fl, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b, input logic [7:0] rd);
        if (u == 0) begin
            if32.start_i = st;  if32.flush_i = fl;  if32.funct3_i = f3;
            if32.rs1_i = a[31:0];  if32.rs2_i = b[31:0];  if32.rd_i = rd[4:0];
        end else begin
            if8.start_i = st;  if8.flush_i = fl;  if8.funct3_i = f3;
            if8.rs1_i = a[7:0];  if8.rs2_i = b[7:0];  if8.rd_i = rd[2:0];
        end
    endtask

    function automatic logic get_done(input int u);
        return (u == 0) ? if32.done_o : if8.done_o;
    endfunction

    function automatic logic get_stall(input int u);
        return (u == 0) ? if32.stall_o : if8.stall_o;
    endfunction

    function automatic logic [63:0] get_res(input int u);
        return (u == 0) ? 64'(if32.result_o) : 64'(if8.result_o);
    endfunction

    // One operation with a hand-computed result; latency counted from the accept edge.
    task automatic run_op(input int u, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input logic [7:0] rd, input logic [63:0] lit,
                          input int lat_exp, input logic fl_after);
        int lat, stalls;
        bit seen;
        @(posedge clk_i); #1;
        set_in(u, 1'b1, 1'b0, f3, a, b, rd);
        @(posedge clk_i); #1;
        set_in(u, 1'b0, fl_after, f3, a, b, rd);
        lat = 0; stalls = 0; seen = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk_i);
            if (get_done(u)) begin
                seen = 1;
                lat  = k;
                chk($sformatf("u%0d_lit_f3_%0d", u, f3), get_res(u), lit);
            end else if (get_stall(u)) begin
                stalls++;
            end
        end
        chk($sformatf("u%0d_latency", u), 64'(lat), 64'(lat_exp));
        chk($sformatf("u%0d_stall_cycles", u), 64'(stalls), 64'(lat_exp - 1));
        set_in(u, 1'b0, 1'b0, f3, a, b, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0);
        set_in(1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0);
        repeat (2) @(negedge clk_i);
        chk("reset_result", get_res(0), 64'd0);
        chk("reset_rd", 64'(if32.rd_o), 64'd0);
        chk("reset_done", {63'd0, if32.done_o}, 64'd0);
        chk("reset_stall", {63'd0, if32.stall_o}, 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        run_op(0, F3_MUL,    64'h7,        64'hFFFFFFFD, 8'd5,  64'hFFFFFFEB, 34, 1'b0);
        run_op(0, F3_MULH,   64'h80000000, 64'h80000000, 8'd6,  64'h40000000, 34, 1'b0);
        run_op(0, F3_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 8'd7,  64'hFFFFFFFE, 34, 1'b0);
        run_op(0, F3_MULHSU, 64'hFFFFFFFF, 64'h2,        8'd8,  64'hFFFFFFFF, 34, 1'b0);
        run_op(0, F3_MULH,   64'hFFFFFFFE, 64'h3,        8'd9,  64'hFFFFFFFF, 34, 1'b0);
        run_op(0, F3_MUL,    64'hFFFFFFFF, 64'hFFFFFFFF, 8'd10, 64'h1,        34, 1'b0);
        run_op(0, F3_DIV,    64'hFFFFFFF9, 64'h2,        8'd11, 64'hFFFFFFFD, 34, 1'b0);
        run_op(0, F3_REM,    64'hFFFFFFF9, 64'h2,        8'd12, 64'hFFFFFFFF, 34, 1'b0);
        run_op(0, F3_DIV,    64'h7,        64'hFFFFFFFE, 8'd13, 64'hFFFFFFFD, 34, 1'b0);
        run_op(0, F3_REM,    64'h7,        64'hFFFFFFFE, 8'd14, 64'h1,        34, 1'b0);
        run_op(0, F3_DIVU,   64'd100,      64'd7,        8'd15, 64'd14,       34, 1'b0);
        run_op(0, F3_REMU,   64'd100,      64'd7,        8'd16, 64'd2,        34, 1'b0);
        run_op(0, F3_DIV,    64'd5,        64'd0,        8'd17, 64'hFFFFFFFF, 1,  1'b0);
        run_op(0, F3_REM,    64'd5,        64'd0,        8'd18, 64'd5,        1,  1'b0);
        run_op(0, F3_DIV,    64'h80000000, 64'hFFFFFFFF, 8'd19, 64'h80000000, 1,  1'b0);
        run_op(0, F3_REM,    64'h80000000, 64'hFFFFFFFF, 8'd20, 64'd0,        1,  1'b1);
        run_op(0, F3_DIVU,   64'h5,        64'd0,        8'd21, 64'hFFFFFFFF, 1,  1'b0);
        run_op(0, F3_REMU,   64'h1234,     64'd0,        8'd22, 64'h1234,     1,  1'b0);
        run_op(0, F3_DIVU,   64'h80000000, 64'hFFFFFFFF, 8'd23, 64'd0,        34, 1'b0);
        run_op(0, F3_REMU,   64'h80000000, 64'hFFFFFFFF, 8'd24, 64'h80000000, 34, 1'b0);

        // Flush in the tenth DIV cycle: back to IDLE, no pulse, result held.
        @(posedge clk_i); #1;
        set_in(0, 1'b1, 1'b0, F3_DIV, 64'd1000, 64'd3, 8'd25);
        @(posedge clk_i); #1;
        set_in(0, 1'b0, 1'b0, F3_DIV, 64'd1000, 64'd3, 8'd25);
        repeat (9) @(posedge clk_i);
        #1 set_in(0, 1'b0, 1'b1, F3_DIV, 64'd1000, 64'd3, 8'd25);
        @(posedge clk_i); #1;
        set_in(0, 1'b0, 1'b0, F3_DIV, 64'd1000, 64'd3, 8'd25);
        @(negedge clk_i);
        chk("flush_stall", {63'd0, if32.stall_o}, 64'd0);
        chk("flush_done", {63'd0, if32.done_o}, 64'd0);
        chk("flush_result_held", get_res(0), 64'h80000000);
        run_op(0, F3_DIVU, 64'd1000, 64'd3, 8'd26, 64'd333, 34, 1'b0);

        run_op(1, F3_MULHU, 64'hFF, 64'hFF, 8'd1, 64'hFE, 10, 1'b0);
        run_op(1, F3_DIV,   64'h80, 64'hFF, 8'd2, 64'h80, 1,  1'b0);
        run_op(1, F3_DIVU,  64'hC8, 64'h0D, 8'd3, 64'h0F, 10, 1'b0);
        run_op(1, F3_REM,   64'hF9, 64'h02, 8'd4, 64'hFF, 10, 1'b0);
        run_op(1, F3_MULH,  64'h80, 64'h80, 8'd5, 64'h40, 10, 1'b0);
        run_op(1, F3_MUL,   64'h0F, 64'h11, 8'd6, 64'hFF, 10, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk_i); #1;
        set_in(0, 1'b1, 1'b0, F3_MUL, 64'd7, 64'd3, 8'd9);
        @(posedge clk_i); #1;
        set_in(0, 1'b0, 1'b0, F3_MUL, 64'd7, 64'd3, 8'd9);
        repeat (5) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_result", get_res(0), 64'd0);
        chk("rst_mid_rd", 64'(if32.rd_o), 64'd0);
        chk("rst_mid_stall", {63'd0, if32.stall_o}, 64'd0);
        chk("rst_mid_done", {63'd0, if32.done_o}, 64'd0);
        chk("rst_mid_result8", get_res(1), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        run_op(0, F3_MUL, 64'd7, 64'd3, 8'd9, 64'd21, 34, 1'b0);

        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
